// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin sequencer sharing one registered comparator.
// Optional one-hot result check enabled by defining COMPARE_ARB_CHECK_EN.
module compare_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      cmp_number0,
  output logic [W-1:0]      cmp_number1,
  output logic              cmp_en,
  input  logic [2:0]        cmp_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_id,
  output logic [2:0]        rsp_result,
  output logic              rsp_err,
  output logic              busy,
  output logic [15:0]       done_count
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    CAPT,
    RESP
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] rr_ptr;
  logic [1:0] win_id;
  logic       win_ok;
  logic [1:0] cand;
  logic       accept;
  logic       rsp_fire;
  logic       bad;

  logic [W-1:0] a_arr [NREQ];
  logic [W-1:0] b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_split
    assign a_arr[g] = req_a[g*W +: W];
    assign b_arr[g] = req_b[g*W +: W];
  end

  // First valid requester at or after rr_ptr, wrapping mod 4.
  always_comb begin
    win_id = rr_ptr;
    win_ok = 1'b0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = rr_ptr + 2'(k);
      if (!win_ok && req_valid[cand]) begin
        win_ok = 1'b1;
        win_id = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && win_ok && !reset)
      req_ready[win_id] = 1'b1;
  end

  assign accept   = (state == IDLE) && win_ok;
  assign rsp_fire = (state == RESP) && rsp_ready;
  assign cmp_en   = (state == EVAL);
  assign busy     = (state != IDLE);

`ifdef COMPARE_ARB_CHECK_EN
  assign bad = !(cmp_result inside {3'b001, 3'b010, 3'b100});
`else
  assign bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (win_ok) state_nx = EVAL;
      EVAL:    state_nx = CAPT;
      CAPT:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      cmp_number0 <= '0;
      cmp_number1 <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_err     <= 1'b0;
      done_count  <= '0;
    end else begin
      if (accept) begin
        cmp_number0 <= a_arr[win_id];
        cmp_number1 <= b_arr[win_id];
        rsp_id      <= win_id;
      end
      if (state == CAPT) begin
        rsp_result <= cmp_result;
        rsp_err    <= bad;
        rsp_valid  <= 1'b1;
      end
      if (rsp_fire) begin
        rsp_valid  <= 1'b0;
        rr_ptr     <= rsp_id + 2'd1;
        done_count <= done_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_compare_arbiter.sv
// tb_compare_arbiter: directed bench with a response scoreboard
// and a registered comparator model behind the arbiter.
module tb_compare_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic [15:0] cmp_number0;
  logic [15:0] cmp_number1;
  logic        cmp_en;
  logic [2:0]  cmp_result = 3'b000;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [2:0]  rsp_result;
  logic        rsp_err;
  logic        busy;
  logic [15:0] done_count;

  int checks   = 0;
  int errors   = 0;
  int rsp_seen = 0;
  int cyc      = 0;

  logic       force_en  = 1'b0;
  logic [2:0] force_val = 3'b000;

  typedef struct packed {
    logic [1:0] id;
    logic [2:0] res;
    logic       err;
  } exp_t;

  exp_t sb[$];

`ifdef COMPARE_ARB_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  compare_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .cmp_number0 (cmp_number0),
    .cmp_number1 (cmp_number1),
    .cmp_en      (cmp_en),
    .cmp_result  (cmp_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .done_count  (done_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] cmp_model(input logic [15:0] a,
                                           input logic [15:0] b);
    if (a < b)       return 3'b001;
    else if (a == b) return 3'b010;
    else             return 3'b100;
  endfunction

  always @(posedge clk)
    if (cmp_en)
      cmp_result <= force_en ? force_val : cmp_model(cmp_number0, cmp_number1);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [2:0] res,
                      input logic err);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.err = err;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      rsp_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL rsp_unexpected: observed id %0d expected none", rsp_id);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_result", 32'(rsp_result), 32'(e.res));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    @(negedge clk);
    while (req_ready === 4'b0000 && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (req_ready === 4'b0000) begin
      checks++;
      errors++;
      $error("FAIL %s: observed no grant expected grant in 12 cycles", tag);
    end
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_seen < target && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rsp_seen < target) begin
      checks++;
      errors++;
      $error("FAIL rsp_timeout: observed %0d expected %0d", rsp_seen, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int prevg;
    int n;
    reset     = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    prevg     = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_cmp_en", 32'(cmp_en), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done_count), 32'h0);
    chk("rst_n0", 32'(cmp_number0), 32'h0);
    chk("rst_n1", 32'(cmp_number1), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_result", 32'(rsp_result), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);

    // single request with latency trace
    tick();
    reset         = 1'b0;
    req_valid     = 4'b0001;
    req_a[15:0]   = 16'h0005;
    req_b[15:0]   = 16'h0009;
    push(2'd0, 3'b001, 1'b0);
    @(negedge clk);
    chk("s_grant", 32'(req_ready), 32'h1);
    chk("s_idle_busy", 32'(busy), 32'h0);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("s_eval_en", 32'(cmp_en), 32'h1);
    chk("s_eval_busy", 32'(busy), 32'h1);
    chk("s_n0", 32'(cmp_number0), 32'h5);
    chk("s_n1", 32'(cmp_number1), 32'h9);
    chk("s_eval_ready", 32'(req_ready), 32'h0);
    tick();
    @(negedge clk);
    chk("s_capt_en", 32'(cmp_en), 32'h0);
    chk("s_capt_valid", 32'(rsp_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("s_resp_valid", 32'(rsp_valid), 32'h1);
    chk("s_resp_id", 32'(rsp_id), 32'h0);
    chk("s_resp_result", 32'(rsp_result), 32'h1);
    tick();
    @(negedge clk);
    chk("s_done_valid", 32'(rsp_valid), 32'h0);
    chk("s_done_busy", 32'(busy), 32'h0);
    chk("s_done_count", 32'(done_count), 32'h1);

    // all four requesters from reset
    tick();
    reset     = 1'b1;
    req_valid = 4'hF;
    req_a     = {4{16'h1234}};
    req_b     = {4{16'h1234}};
    for (int i = 0; i < 4; i++) push(2'(i), 3'b010, 1'b0);
    tick();
    reset = 1'b0;
    base  = rsp_seen;
    for (int i = 0; i < 4; i++) begin
      wait_grant("rr_wait");
      chk("rr_grant", 32'(req_ready), 32'(1) << i);
      if (i > 0) chk("rr_interval", 32'(cyc - prevg), 32'd4);
      prevg = cyc;
      tick();
      req_valid[i] = 1'b0;
    end
    wait_rsp(base + 4);
    tick();
    @(negedge clk);
    chk("rr_done", 32'(done_count), 32'd4);

    // rotation after serving requester 2
    tick();
    base          = rsp_seen;
    req_valid     = 4'b0100;
    req_a[47:32]  = 16'h0007;
    req_b[47:32]  = 16'h0003;
    push(2'd2, 3'b100, 1'b0);
    wait_grant("rot_wait");
    chk("rot_grant2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    wait_rsp(base + 1);
    tick();
    req_valid     = 4'b0101;
    req_a[15:0]   = 16'h0001;
    req_b[15:0]   = 16'h0002;
    req_a[47:32]  = 16'h0009;
    req_b[47:32]  = 16'h0009;
    push(2'd0, 3'b001, 1'b0);
    push(2'd2, 3'b010, 1'b0);
    wait_grant("rot_wait");
    chk("rot_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid[0] = 1'b0;
    wait_grant("rot_wait");
    chk("rot_grant2b", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    wait_rsp(base + 3);

    // backpressure
    tick();
    base          = rsp_seen;
    rsp_ready     = 1'b0;
    req_valid     = 4'b0010;
    req_a[31:16]  = 16'hFFFF;
    req_b[31:16]  = 16'h0000;
    push(2'd1, 3'b100, 1'b0);
    wait_grant("bp_wait");
    chk("bp_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0001;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_rise", 32'(rsp_valid), 32'h1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_id", 32'(rsp_id), 32'h1);
      chk("bp_result", 32'(rsp_result), 32'h4);
      chk("bp_ready0", 32'(req_ready), 32'h0);
      chk("bp_count", 32'(done_count), 32'd7);
      tick();
      @(negedge clk);
    end
    tick();
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    tick();
    @(negedge clk);
    chk("bp_done_valid", 32'(rsp_valid), 32'h0);
    chk("bp_done_count", 32'(done_count), 32'd8);
    wait_rsp(base + 1);

    // reset while in EVAL
    tick();
    req_valid     = 4'b1000;
    req_a[63:48]  = 16'h0003;
    req_b[63:48]  = 16'h0003;
    wait_grant("ar_wait");
    chk("ar_grant", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("ar_eval_en", 32'(cmp_en), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("ar_cmp_en", 32'(cmp_en), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_valid", 32'(rsp_valid), 32'h0);
    chk("ar_n0", 32'(cmp_number0), 32'h0);
    chk("ar_count", 32'(done_count), 32'h0);
    chk("ar_id", 32'(rsp_id), 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ar_no_rsp", 32'(rsp_valid), 32'h0);
    end
    tick();
    base          = rsp_seen;
    req_valid     = 4'b1010;
    req_a[31:16]  = 16'h0002;
    req_b[31:16]  = 16'h0001;
    push(2'd1, 3'b100, 1'b0);
    wait_grant("ar_wait");
    chk("ar_first_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    wait_rsp(base + 1);
    tick();
    @(negedge clk);
    chk("ar_count1", 32'(done_count), 32'd1);

    // non-one-hot comparator output
    tick();
    base         = rsp_seen;
    force_en     = 1'b1;
    force_val    = 3'b011;
    req_valid    = 4'b0001;
    req_a[15:0]  = 16'h0001;
    req_b[15:0]  = 16'h0001;
    push(2'd0, 3'b011, EXP_ERR);
    wait_grant("err_wait");
    chk("err_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    wait_rsp(base + 1);
    tick();
    force_en = 1'b0;

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
